// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues sequential word reads to memory
// port 0, buffers returned words and hands them to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] mem_rd_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rd_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   fetch_pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic          drop;
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [31:0]   ent_instr [DEPTH];
  logic [31:0]   ent_pc    [DEPTH];

  logic          deq;
  logic          push;
  logic          issue;
  logic [CW:0]   occ;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credit check counts the word already in flight so the buffer never overflows.
  always_comb begin
    out_valid    = (count != '0);
    deq          = out_valid && out_ready;
    occ          = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(deq);
    issue        = rst_n && !redirect_valid && (occ < (CW+1)'(DEPTH));
    push         = inflight && !drop && !redirect_valid;
    mem_rd_en    = issue;
    mem_rd_addr  = fetch_pc;
    out_instr    = out_valid ? ent_instr[rd_ptr] : '0;
    out_pc       = out_valid ? ent_pc[rd_ptr]    : '0;
    out_pc_plus4 = out_valid ? ent_pc[rd_ptr] + 32'd4 : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= '0;
      inflight    <= 1'b0;
      drop        <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        drop     <= inflight;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        drop  <= 1'b0;
        count <= count + CW'(push) - CW'(deq);
        if (push) wr_ptr <= bump(wr_ptr);
        if (deq)  rd_ptr <= bump(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_instr[wr_ptr] <= mem_rd_data;
      ent_pc[wr_ptr]    <= inflight_pc;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule
